// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit. Owns the program counter, drives the instruction
// ROM address and registers the returned word for the decode stage. Handles
// start/halt sequencing, stalls, absolute branch redirection with a single
// squashed fall-through fetch, and counts issued instructions.
//
// Parameters
//   A   instruction address width (ROM depth 2**A)
//   W   instruction word width
//   CW  issued-instruction counter width
//
// Ports
//   Clk          in   rising-edge clock
//   Reset_n      in   asynchronous active-low reset
//   Start        in   begin execution at address 0 (honoured in IDLE/HALTED)
//   Stall        in   freeze the fetch pipeline this cycle
//   BranchEn     in   the word on InstOut is a taken branch
//   Target       in   absolute branch target
//   InstIn       in   ROM data, combinational from InstAddress
//   InstAddress  out  program counter / ROM address
//   InstOut      out  registered instruction word
//   InstValid    out  InstOut holds a live instruction
//   Done         out  halt word has been fetched
//   InstCount    out  saturating count of issued instructions since Start
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int A  = 12,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic [A-1:0]  Target,
    input  logic [W-1:0]  InstIn,
    output logic [A-1:0]  InstAddress,
    output logic [W-1:0]  InstOut,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] InstCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic [W-1:0]  inst_q, inst_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [CW-1:0] count_q, count_d;

    // The halt opcode is the all-ones instruction word.
    logic halt_word;
    // A branch is only meaningful when the word on InstOut is live.
    logic take_branch;
    logic count_max;

    assign halt_word   = &InstIn;
    assign take_branch = BranchEn && valid_q;
    assign count_max   = &count_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        done_d  = done_q;
        count_d = count_q;

        unique case (state_q)
            ST_IDLE: begin
                pc_d    = '0;
                valid_d = 1'b0;
                if (Start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end

            ST_RUN: begin
                // Stall freezes everything and overrides branch and halt.
                if (!Stall) begin
                    if (take_branch) begin
                        // Fall-through word fetched this cycle is dropped:
                        // not captured, not counted, not checked for halt.
                        pc_d    = Target;
                        valid_d = 1'b0;
                    end else begin
                        inst_d  = InstIn;
                        valid_d = 1'b1;
                        if (!count_max) begin
                            count_d = count_q + 1'b1;
                        end
                        if (halt_word) begin
                            // Halt word is issued and counted, PC stays on it.
                            state_d = ST_HALTED;
                            done_d  = 1'b1;
                        end else begin
                            pc_d = pc_q + 1'b1;  // wraps modulo 2**A
                        end
                    end
                end
            end

            ST_HALTED: begin
                // The halt word was valid for exactly one cycle; from here
                // on the output is frozen but no longer live.
                valid_d = 1'b0;
                done_d  = 1'b1;
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    done_d  = 1'b0;
                    count_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign InstAddress = pc_q;
    assign InstOut     = inst_q;
    assign InstValid   = valid_q;
    assign Done        = done_q;
    assign InstCount   = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed self-checking bench for inst_fetch. A full-size instance
// (A=12, CW=16) covers start, halt, branch, stall, squashed halt and
// asynchronous reset; a small instance (A=4, CW=4) covers PC wrap-around
// and counter saturation. Each DUT reads a combinational ROM model.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    logic clk;
    logic rst_n;

    // Main instance signals
    logic        m_start, m_stall, m_branch;
    logic [11:0] m_target;
    logic [8:0]  m_inst_in;
    logic [11:0] m_addr;
    logic [8:0]  m_inst_out;
    logic        m_valid, m_done;
    logic [15:0] m_cnt;
    logic [8:0]  rom_m [0:4095];

    // Small instance signals
    logic        s_start, s_stall, s_branch;
    logic [3:0]  s_target;
    logic [8:0]  s_inst_in;
    logic [3:0]  s_addr;
    logic [8:0]  s_inst_out;
    logic        s_valid, s_done;
    logic [3:0]  s_cnt;
    logic [8:0]  rom_s [0:15];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    assign m_inst_in = rom_m[m_addr];
    assign s_inst_in = rom_s[s_addr];

    inst_fetch #(.A(12), .W(9), .CW(16)) u_main (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .Start       (m_start),
        .Stall       (m_stall),
        .BranchEn    (m_branch),
        .Target      (m_target),
        .InstIn      (m_inst_in),
        .InstAddress (m_addr),
        .InstOut     (m_inst_out),
        .InstValid   (m_valid),
        .Done        (m_done),
        .InstCount   (m_cnt)
    );

    inst_fetch #(.A(4), .W(9), .CW(4)) u_small (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .Start       (s_start),
        .Stall       (s_stall),
        .BranchEn    (s_branch),
        .Target      (s_target),
        .InstIn      (s_inst_in),
        .InstAddress (s_addr),
        .InstOut     (s_inst_out),
        .InstValid   (s_valid),
        .Done        (s_done),
        .InstCount   (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s obs=%0h", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output of the main instance.
    task automatic chk_m(input string tag, input int inst, input int valid,
                         input int addr, input int cnt, input int done);
        check({tag, ".inst"},  32'(m_inst_out), 32'(inst));
        check({tag, ".valid"}, 32'(m_valid),    32'(valid));
        check({tag, ".addr"},  32'(m_addr),     32'(addr));
        check({tag, ".cnt"},   32'(m_cnt),      32'(cnt));
        check({tag, ".done"},  32'(m_done),     32'(done));
    endtask

    // Checks the main instance during a bubble, where InstOut is don't-care.
    task automatic chk_bubble(input string tag, input int addr, input int cnt, input int done);
        check({tag, ".valid"}, 32'(m_valid), 32'd0);
        check({tag, ".addr"},  32'(m_addr),  32'(addr));
        check({tag, ".cnt"},   32'(m_cnt),   32'(cnt));
        check({tag, ".done"},  32'(m_done),  32'(done));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        m_start  = 1'b0;
        m_stall  = 1'b0;
        m_branch = 1'b0;
        m_target = '0;
        s_start  = 1'b0;
        s_stall  = 1'b0;
        s_branch = 1'b0;
        s_target = '0;
        for (int i = 0; i < 4096; i++) rom_m[i] = 9'h000;
        for (int i = 0; i < 16; i++)   rom_s[i] = 9'(9'h010 + i);

        // ---------------- Reset and idle ----------------
        #12;
        chk_m("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk_m("idle", 0, 0, 0, 0, 0);

        // ---------------- Start, run to halt ----------------
        rom_m[0] = 9'h001;
        rom_m[1] = 9'h002;
        rom_m[2] = 9'h003;
        rom_m[3] = 9'h1FF;
        m_start = 1'b1;
        step();
        m_start = 1'b0;
        chk_m("start", 0, 0, 0, 0, 0);
        step(); chk_m("run_w0", 9'h001, 1, 1, 1, 0);
        step(); chk_m("run_w1", 9'h002, 1, 2, 2, 0);
        step(); chk_m("run_w2", 9'h003, 1, 3, 3, 0);
        step(); chk_m("run_halt", 9'h1FF, 1, 3, 4, 1);
        step(); chk_m("halted", 9'h1FF, 0, 3, 4, 1);
        step(); chk_m("halted_hold", 9'h1FF, 0, 3, 4, 1);

        // ---------------- Restart from HALTED, branch ----------------
        rom_m[0]     = 9'h011;
        rom_m[1]     = 9'h012;
        rom_m[2]     = 9'h013;
        rom_m[3]     = 9'h014;
        rom_m[12'h040] = 9'h0AB;
        rom_m[12'h041] = 9'h0AC;
        m_start = 1'b1;
        step();
        chk_bubble("restart", 0, 0, 0);
        // Start held into RUN must be ignored
        step(); chk_m("br_w0", 9'h011, 1, 1, 1, 0);
        m_start = 1'b0;
        step(); chk_m("br_w1", 9'h012, 1, 2, 2, 0);
        step(); chk_m("br_w2", 9'h013, 1, 3, 3, 0);
        m_branch = 1'b1;
        m_target = 12'h040;
        step(); chk_bubble("br_bubble", 12'h040, 3, 0);
        m_branch = 1'b0;
        step(); chk_m("br_tgt0", 9'h0AB, 1, 12'h041, 4, 0);
        step(); chk_m("br_tgt1", 9'h0AC, 1, 12'h042, 5, 0);

        // ---------------- Asynchronous reset mid-run ----------------
        #3;
        rst_n = 1'b0;
        #1;
        chk_m("rst_mid", 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        step(); chk_m("post_rst", 0, 0, 0, 0, 0);
        step(); chk_m("idle_wait", 0, 0, 0, 0, 0);

        // ---------------- Stall ----------------
        for (int i = 0; i < 8; i++) rom_m[i] = 9'(9'h100 + i);
        m_start = 1'b1;
        step();
        m_start = 1'b0;
        chk_bubble("st_start", 0, 0, 0);
        repeat (6) step();
        chk_m("st_pre", 9'h105, 1, 6, 6, 0);
        m_stall  = 1'b1;
        m_branch = 1'b1;   // stall dominates a branch request
        m_target = 12'h020;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_m("stall", 9'h105, 1, 6, 6, 0);
        end
        m_stall  = 1'b0;
        m_branch = 1'b0;
        step(); chk_m("st_resume", 9'h106, 1, 7, 7, 0);

        // ---------------- Squashed halt ----------------
        rom_m[7]       = 9'h0C7;
        rom_m[8]       = 9'h1FF;
        rom_m[12'h010] = 9'h0D0;
        step(); chk_m("sq_br", 9'h0C7, 1, 8, 8, 0);
        m_branch = 1'b1;
        m_target = 12'h010;
        step(); chk_bubble("sq_bubble", 12'h010, 8, 0);
        m_branch = 1'b0;
        step(); chk_m("sq_tgt", 9'h0D0, 1, 12'h011, 9, 0);

        // ---------------- Wrap-around and saturation (A=4, CW=4) ----------------
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("wr_start.addr", 32'(s_addr), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            check($sformatf("wr%0d.addr", k),  32'(s_addr),     32'(k % 16));
            check($sformatf("wr%0d.inst", k),  32'(s_inst_out), 32'(9'h010 + ((k - 1) % 16)));
            check($sformatf("wr%0d.cnt", k),   32'(s_cnt),      32'((k > 15) ? 15 : k));
            check($sformatf("wr%0d.valid", k), 32'(s_valid),    32'd1);
        end
        check("wr.done", 32'(s_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
